// File: rtl/nandc_page_xfer.sv
// Byte-lane adapter between the 8-bit NAND data path and one 32-bit port of the
// page buffer RAM. Read direction packs bytes into little-endian words; program
// direction fetches words and serialises them byte by byte.
module nandc_page_xfer #(
    parameter int unsigned ADDR  = 10,
    parameter int unsigned DEPTH = 517,
    parameter int unsigned LEN_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             bram_wr,
    output logic [ADDR-1:0]  bram_addr,
    output logic [31:0]      bram_din,
    input  logic [31:0]      bram_dout
);

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(DEPTH * 4);

    typedef enum logic [2:0] {
        StIdle, StRdFill, StRdFlush, StPgFetch, StPgWait, StPgShift, StFin
    } state_e;

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [1:0]       lane_q, lane_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic [31:0]      pack_q, pack_d;
    logic [31:0]      shift_q, shift_d;
    logic             wr_q, wr_d;
    logic [ADDR-1:0]  wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;

    logic        last_byte;
    logic        in_fire;
    logic        out_fire;
    logic [31:0] merged;

    assign last_byte = (cnt_q == len_q - LEN_W'(1));
    assign in_fire   = (state_q == StRdFill) && !abort && in_valid;
    assign out_fire  = (state_q == StPgShift) && !abort && out_ready;

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            lane_q    <= '0;
            addr_q    <= '0;
            pack_q    <= 32'hFFFF_FFFF;
            shift_q   <= '0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            lane_q    <= lane_d;
            addr_q    <= addr_d;
            pack_q    <= pack_d;
            shift_q   <= shift_d;
            wr_q      <= wr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (len == '0 || len > MaxLen) state_d = StFin;
                    else if (dir)                  state_d = StPgFetch;
                    else                           state_d = StRdFill;
                end
            end
            StRdFill:  if (in_fire && last_byte) state_d = StRdFlush;
            StRdFlush: state_d = StFin;
            StPgFetch: state_d = StPgWait;
            StPgWait:  state_d = StPgShift;
            StPgShift: begin
                if (out_fire) begin
                    if (last_byte)            state_d = StFin;
                    else if (lane_q == 2'd3)  state_d = StPgFetch;
                end
            end
            StFin:     state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (abort && state_q != StIdle) state_d = StIdle;
    end

    // Datapath next-state: counters, pack/shift registers, write staging
    always_comb begin
        dir_d     = dir_q;
        err_d     = err_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        lane_d    = lane_q;
        addr_d    = addr_q;
        pack_d    = pack_q;
        shift_d   = shift_q;
        wr_d      = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        merged    = pack_q;
        merged[{lane_q, 3'b000} +: 8] = in_data;

        if (state_q == StIdle && start) begin
            dir_d  = dir;
            len_d  = len;
            err_d  = (len > MaxLen);
            cnt_d  = '0;
            lane_d = '0;
            addr_d = '0;
            pack_d = 32'hFFFF_FFFF;
        end

        if (in_fire) begin
            cnt_d  = cnt_q + LEN_W'(1);
            lane_d = lane_q + 2'd1;
            if (lane_q == 2'd3 || last_byte) begin
                // Word complete (or final partial word, pad lanes stay 0xFF)
                wr_d      = 1'b1;
                wr_addr_d = ADDR'(cnt_q >> 2);
                wr_data_d = merged;
                pack_d    = 32'hFFFF_FFFF;
            end else begin
                pack_d = merged;
            end
        end

        if (state_q == StPgWait) shift_d = bram_dout;

        if (out_fire) begin
            cnt_d  = cnt_q + LEN_W'(1);
            lane_d = lane_q + 2'd1;
            if (!last_byte && lane_q == 2'd3) addr_d = addr_q + ADDR'(1);
        end

        // Abort drops any partially packed word
        if (abort && state_q != StIdle) pack_d = 32'hFFFF_FFFF;
    end

    // Output decode
    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StFin);
        err       = (state_q == StFin) && err_q;
        in_ready  = (state_q == StRdFill) && !abort;
        out_valid = (state_q == StPgShift) && !abort;
        out_data  = shift_q[{lane_q, 3'b000} +: 8];
        bram_wr   = wr_q;
        bram_addr = dir_q ? addr_q : wr_addr_q;
        bram_din  = wr_data_q;
    end

endmodule

// File: doc/nandc_page_xfer.md
Name: nandc_page_xfer

Overview:
Byte-lane adapter between the 8-bit NAND data path and one 32-bit port of the NAND page buffer RAM: 517 words, one-cycle registered read, write-through.
- Read direction: packs incoming NAND bytes into little-endian words and writes them to the buffer.
- Program direction: fetches buffer words and serialises them as bytes to the NAND data path.
- The page controller drives one transfer at a time.

Parameters:
ADDR, 10, buffer word-address width
DEPTH, 517, buffer depth in 32-bit words; max transfer = DEPTH*4 = 2068 bytes
LEN_W, 12, width of the byte-length field

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
dir  in  1  0 = NAND read (bytes to buffer), 1 = NAND program (buffer to bytes); sampled with start
len  in  LEN_W  byte count; sampled with start
abort  in  1  synchronous cancel; returns to IDLE without done
busy  out  1  high from the cycle after an accepted start until return to IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse coincident with done when len > DEPTH*4
in_valid  in  1  NAND read byte valid
in_data  in  8  NAND read byte
in_ready  out  1  byte accepted when in_valid & in_ready
out_valid  out  1  program byte valid
out_data  out  8  program byte
out_ready  in  1  byte consumed when out_valid & out_ready
bram_wr  out  1  buffer write strobe
bram_addr  out  ADDR  buffer word address
bram_din  out  32  buffer write data
bram_dout  in  32  buffer read data, valid one cycle after bram_addr is presented

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter, word address and lane index 0; pack register 0xFFFFFFFF.
- States: IDLE, RD_FILL, RD_FLUSH, PG_FETCH, PG_WAIT, PG_SHIFT, FIN.
- IDLE + start:
  - len == 0 or len > DEPTH*4: go to FIN; err = (len > DEPTH*4); no buffer access.
  - dir = 0: go to RD_FILL.
  - dir = 1: go to PG_FETCH.
  - Addresses always start at word 0.
- Start while busy is ignored.
- RD_FILL:
  - in_ready = 1.
  - Byte k (0-based) is written into lane k%4, i.e. bits [8*(k%4)+7 : 8*(k%4)].
  - When lane 3 is filled, or the byte is the last one (k = len-1):
    - next cycle: bram_wr = 1 for exactly one cycle, bram_addr = k/4, bram_din = packed word;
    - unfilled lanes of a final partial word read 0xFF (erased-NAND pad);
    - pack register reloads 0xFFFFFFFF.
  - Sustains one byte per cycle with no bubbles; bram_wr overlaps continued byte acceptance.
  - After the last byte: in_ready drops in the next cycle, then RD_FLUSH issues the final write, then FIN.
- PG_FETCH: drive bram_addr = current word; go to PG_WAIT.
- PG_WAIT: capture bram_dout into the shift register; go to PG_SHIFT.
- PG_SHIFT:
  - out_valid = 1; out_data = lane (k%4) of the captured word.
  - Byte advances on out_ready.
  - After lane 3: if bytes remain, word address +1 and go to PG_FETCH (two-cycle bubble between words).
  - After the last byte (k = len-1): go to FIN; the remaining lanes are discarded.
  - out_data is held stable while out_valid & !out_ready.
- FIN: done = 1 (err as decided at start) for one cycle; busy = 0 from the next cycle; return to IDLE.
- abort in any non-IDLE state:
  - next cycle IDLE; busy = 0; no done.
  - A pending partial word is dropped; no write is issued.
  - in_ready and out_valid are deasserted in the same cycle abort is seen.
- Reset mid-transfer: immediate return to reset values; a pending write is lost.
- Word address never exceeds DEPTH-1 because len is range-checked; the counter is LEN_W bits with no wrap.
- bram_wr is never asserted in the program direction.

Test Plan:
- Read len=8, bytes 0x01..0x08 back-to-back: word0 = 0x04030201, word1 = 0x08070605 written at addr 0/1; one done pulse; in_ready high for exactly 8 cycles.
- Read len=6, bytes 0xA0..0xA5: word1 = 0xFFFFA5A4; exactly 2 bram_wr pulses.
- Program len=5, buffer word0 = 0x44332211, word1 = 0x88776655: out_data 0x11,0x22,0x33,0x44,0x55; out_ready toggled randomly; data held while stalled; done after the 5th byte.
- Length edges: len=0 gives done, err=0, no buffer access; len=2069 gives done and err=1, no bram_wr; len=2068 read writes addr 0..516.
- Read with in_valid gaps (1 of every 3 cycles), len=12: 3 correct words; done one cycle after the 3rd write.
- abort after 3 bytes of a read: no bram_wr, no done, busy low next cycle. A following start is accepted. rst_n pulsed mid-program: out_valid = 0 immediately.
